stack_context_unit: RTL and testbench

- Sits directly upstream of the CPU hardware stack (32-bit wide, 1024 entries) and is the only master of its push/pop/d port.
- In normal operation it forwards single push/pop requests from the CPU datapath to the stack.
- On interrupt entry and return it runs a burst: it saves a contiguous range of registers onto the stack, or restores them from it.
- It tracks stack occupancy and blocks any overflow or underflow, which the stack itself cannot detect.

---
 rtl/stack_context_unit_pkg.sv | 17 +
 rtl/stack_depth_tracker.sv | 55 +++++
 rtl/stack_context_unit.sv | 151 +++++++++++++++
 tb/tb_stack_context_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_context_unit_pkg.sv
// Shared definitions for the stack context unit: burst FSM encoding and
// default sizing of the hardware stack it fronts.
package stack_context_unit_pkg;

  localparam int DEFAULT_DEPTH = 1024;
  localparam int REG_IDX_W     = 4;
  localparam int DEPTH_W       = 11;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    RESTORE,
    RTAIL,
    FIN
  } state_t;

endpackage

// File: rtl/stack_depth_tracker.sv
// Occupancy counter for a stack master: gates push/pop strobes that would
// overflow or underflow and keeps sticky error flags.
module stack_depth_tracker
  import stack_context_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_req,
  input  logic               pop_req,
  input  logic               ovf_set,
  input  logic               unf_set,
  input  logic               err_clr,
  output logic               push_ok,
  output logic               pop_ok,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_ovf,
  output logic               err_unf
);

  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(DEPTH);

  logic full;
  logic empty;
  logic ovf_hit;
  logic unf_hit;

  assign full    = (depth == FULL);
  assign empty   = (depth == '0);
  assign push_ok = push_req && !full;
  assign pop_ok  = pop_req && !empty;
  assign ovf_hit = ovf_set || (push_req && full);
  assign unf_hit = unf_set || (pop_req && empty);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push_ok && !pop_ok)      depth <= depth + 1'b1;
      else if (pop_ok && !push_ok) depth <= depth - 1'b1;

      // A new error in the same cycle as a clear must survive.
      if (ovf_hit)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (unf_hit)      err_unf <= 1'b1;
      else if (err_clr) err_unf <= 1'b0;
    end
  end

endmodule

// File: rtl/stack_context_unit.sv
// Sole master of the CPU hardware stack: forwards single push/pop requests and
// runs register save/restore bursts on interrupt entry and return.
module stack_context_unit
  import stack_context_unit_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 15,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_push,
  input  logic        cpu_pop,
  input  logic [31:0] cpu_d,
  output logic [31:0] cpu_q,
  input  logic        save_req,
  input  logic        restore_req,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_unf,
  input  logic        err_clr,
  output logic [10:0] depth,
  output logic [3:0]  reg_raddr,
  input  logic [31:0] reg_rdata,
  output logic [3:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic [31:0] stk_d,
  output logic        stk_push,
  output logic        stk_pop,
  input  logic [31:0] stk_q
);

  localparam int N = LAST_REG - FIRST_REG + 1;
  localparam logic [REG_IDX_W-1:0] FIRST_IDX  = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX   = REG_IDX_W'(LAST_REG);
  localparam logic [DEPTH_W-1:0]   SAVE_LIMIT = DEPTH_W'(DEPTH - N);
  localparam logic [DEPTH_W-1:0]   BURST_LEN  = DEPTH_W'(N);

  state_t               state, state_d;
  logic [REG_IDX_W-1:0] idx, idx_d;
  logic                 wr_pend;
  logic [REG_IDX_W-1:0] wr_idx;
  logic                 push_req, pop_req, push_ok, pop_ok;
  logic                 ovf_set, unf_set;
  logic                 save_fits, restore_fits;

  assign save_fits    = (depth <= SAVE_LIMIT);
  assign restore_fits = (depth >= BURST_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      wr_pend <= 1'b0;
      wr_idx  <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      // Popped data arrives a cycle after the pop, so the write trails by one.
      wr_pend <= (state == RESTORE);
      wr_idx  <= idx;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: begin
        if (save_req) begin
          state_d = save_fits ? SAVE : FIN;
          idx_d   = FIRST_IDX;
        end else if (restore_req) begin
          state_d = restore_fits ? RESTORE : FIN;
          idx_d   = LAST_IDX;
        end
      end
      SAVE: begin
        idx_d = idx + 1'b1;
        if (idx == LAST_IDX) state_d = FIN;
      end
      RESTORE: begin
        idx_d = idx - 1'b1;
        if (idx == FIRST_IDX) state_d = RTAIL;
      end
      RTAIL:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    push_req  = 1'b0;
    pop_req   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    stk_d     = cpu_d;
    reg_raddr = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // Burst requests outrank CPU traffic; a simultaneous push is dropped.
        if (save_req)         ovf_set  = !save_fits;
        else if (restore_req) unf_set  = !restore_fits;
        else if (cpu_pop)     pop_req  = 1'b1;
        else if (cpu_push)    push_req = 1'b1;
      end
      SAVE: begin
        busy      = 1'b1;
        reg_raddr = idx;
        stk_d     = reg_rdata;
        push_req  = 1'b1;
      end
      RESTORE: begin
        busy    = 1'b1;
        pop_req = 1'b1;
      end
      RTAIL:   busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  stack_depth_tracker #(.DEPTH(DEPTH)) u_depth (
    .clk     (clk),
    .reset   (reset),
    .push_req(push_req),
    .pop_req (pop_req),
    .ovf_set (ovf_set),
    .unf_set (unf_set),
    .err_clr (err_clr),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .depth   (depth),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
  );

  assign stk_push  = push_ok;
  assign stk_pop   = pop_ok;
  assign cpu_q     = stk_q;
  assign reg_we    = wr_pend;
  assign reg_waddr = wr_idx;
  assign reg_wdata = stk_q;

endmodule

// File: tb/tb_stack_context_unit.sv
// Scoreboard bench for stack_context_unit with behavioural stack and register
// file models; expected events are queued by stimulus and popped by a monitor.
module tb_stack_context_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_push = 1'b0, cpu_pop = 1'b0;
  logic [31:0] cpu_d = '0;
  logic [31:0] cpu_q;
  logic        save_req = 1'b0, restore_req = 1'b0;
  logic        busy, done, err_ovf, err_unf;
  logic        err_clr = 1'b0;
  logic [10:0] depth;
  logic [3:0]  reg_raddr, reg_waddr;
  logic [31:0] reg_rdata, reg_wdata;
  logic        reg_we;
  logic [31:0] stk_d;
  logic        stk_push, stk_pop;
  logic [31:0] stk_q = '0;

  stack_context_unit dut (
    .clk(clk), .reset(reset),
    .cpu_push(cpu_push), .cpu_pop(cpu_pop), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_unf(err_unf),
    .err_clr(err_clr), .depth(depth),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .stk_d(stk_d), .stk_push(stk_push), .stk_pop(stk_pop), .stk_q(stk_q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack model: strobes sampled on the falling edge, q updated on the rising edge.
  logic [31:0] mem [0:1023];
  int          sp = 0;
  logic [31:0] q_next = '0;
  always @(negedge clk) begin
    if (reset) sp <= 0;
    else if (stk_push && sp < 1024) begin
      mem[sp] <= stk_d;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      q_next <= mem[sp-1];
      sp     <= sp - 1;
    end
  end
  always @(posedge clk) stk_q <= q_next;

  // Register file model: combinational read, write on the rising edge.
  logic [31:0] rf [0:15];
  logic        rf_load = 1'b0;
  logic [31:0] rf_base = '0;
  assign reg_rdata = rf[reg_raddr];
  always @(posedge clk) begin
    if (rf_load) for (int i = 0; i < 16; i++) rf[i] <= rf_base + 32'(i);
    else if (reg_we) rf[reg_waddr] <= reg_wdata;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] push_q[$];
  logic [31:0] cpuq_q[$];
  logic [35:0] wr_q[$];
  int          done_q[$];

  // Monitor: compare every observed output event against the queued expectation.
  logic pop_pending = 1'b0;
  always @(negedge clk) begin
    if (stk_push) begin
      if (push_q.size() > 0) check("push_data", 64'(stk_d), 64'(push_q.pop_front()));
      else check("unexpected_push", 64'(stk_push), 64'd0);
    end
    if (pop_pending) begin
      if (cpuq_q.size() > 0) check("cpu_q", 64'(cpu_q), 64'(cpuq_q.pop_front()));
      else check("unexpected_pop", 64'(pop_pending), 64'd0);
    end
    pop_pending = stk_pop && !busy;
    if (reg_we) begin
      if (wr_q.size() > 0) check("reg_write", 64'({reg_waddr, reg_wdata}), 64'(wr_q.pop_front()));
      else check("unexpected_write", 64'(reg_we), 64'd0);
    end
    if (done) begin
      if (done_q.size() > 0) check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      else check("unexpected_done", 64'(done), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] abc [3];
    abc[0] = 32'hA; abc[1] = 32'hB; abc[2] = 32'hC;

    rf_base = 32'h100; rf_load = 1'b1;
    step(); step();
    rf_load = 1'b0; reset = 1'b0;
    mid();
    check("rst_depth", 64'(depth), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'({err_ovf, err_unf}), 64'd0);
    check("rst_strobes", 64'({stk_push, stk_pop, reg_we}), 64'd0);
    check("rst_raddr", 64'(reg_raddr), 64'd0);
    step();

    // Forwarded pushes then pops, LIFO order on cpu_q.
    for (int i = 0; i < 3; i++) begin
      cpu_push = 1'b1; cpu_d = abc[i]; push_q.push_back(abc[i]);
      step();
    end
    cpu_push = 1'b0;
    mid(); check("depth_after_push", 64'(depth), 64'd3); step();
    for (int i = 2; i >= 0; i--) begin
      cpu_pop = 1'b1; cpuq_q.push_back(abc[i]);
      step();
    end
    cpu_pop = 1'b0;
    step();
    mid(); check("depth_after_pop", 64'(depth), 64'd0); step();

    // Underflow on an empty stack, then clear.
    cpu_pop = 1'b1;
    mid(); check("unf_pop_blocked", 64'(stk_pop), 64'd0); step();
    cpu_pop = 1'b0;
    mid();
    check("err_unf_set", 64'(err_unf), 64'd1);
    check("depth_unf", 64'(depth), 64'd0);
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    mid(); check("err_unf_clr", 64'(err_unf), 64'd0); step();

    // Save burst of r1..r15.
    for (int i = 1; i <= 15; i++) push_q.push_back(32'h100 + 32'(i));
    done_q.push_back(cyc + 16);
    save_req = 1'b1; step(); save_req = 1'b0;
    mid(); check("save_busy", 64'(busy), 64'd1); step();
    repeat (17) step();
    mid();
    check("save_pushes_left", 64'(push_q.size()), 64'd0);
    check("save_done_left", 64'(done_q.size()), 64'd0);
    check("save_depth", 64'(depth), 64'd15);
    step();

    // Clobber registers, restore them from the stack.
    rf_base = 32'hDEAD0000; rf_load = 1'b1; step(); rf_load = 1'b0;
    for (int i = 15; i >= 1; i--) wr_q.push_back({4'(i), 32'h100 + 32'(i)});
    done_q.push_back(cyc + 17);
    restore_req = 1'b1; step(); restore_req = 1'b0;
    repeat (19) step();
    mid();
    check("restore_writes_left", 64'(wr_q.size()), 64'd0);
    check("restore_done_left", 64'(done_q.size()), 64'd0);
    check("restore_depth", 64'(depth), 64'd0);
    for (int i = 1; i <= 15; i++) check("rf_restored", 64'(rf[i]), 64'(32'h100 + 32'(i)));
    step();

    // Fill to 1015, then a save that does not fit.
    for (int i = 0; i < 1015; i++) begin
      cpu_push = 1'b1; cpu_d = 32'(i); push_q.push_back(32'(i));
      step();
    end
    cpu_push = 1'b0;
    mid(); check("fill_depth", 64'(depth), 64'd1015); step();
    done_q.push_back(cyc + 1);
    save_req = 1'b1; step(); save_req = 1'b0;
    step(); step();
    mid();
    check("ovf_flag", 64'(err_ovf), 64'd1);
    check("ovf_depth", 64'(depth), 64'd1015);
    check("ovf_done_left", 64'(done_q.size()), 64'd0);
    step();

    // Reset, then a restore with nothing to restore.
    reset = 1'b1; step(); step(); reset = 1'b0;
    mid();
    check("reset2_depth", 64'(depth), 64'd0);
    check("reset2_err", 64'({err_ovf, err_unf}), 64'd0);
    step();
    done_q.push_back(cyc + 1);
    restore_req = 1'b1; step(); restore_req = 1'b0;
    step(); step();
    mid();
    check("restore_unf_flag", 64'(err_unf), 64'd1);
    check("restore_unf_depth", 64'(depth), 64'd0);
    check("restore_unf_done_left", 64'(done_q.size()), 64'd0);
    step();

    // Colliding requests: save wins, push dropped; reset in SAVE cycle 5 aborts.
    for (int i = 1; i <= 5; i++) push_q.push_back(32'h100 + 32'(i));
    cpu_push = 1'b1; cpu_d = 32'hBAD; save_req = 1'b1; restore_req = 1'b1;
    step();
    cpu_push = 1'b0; save_req = 1'b0; restore_req = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    mid(); check("abort_busy_before", 64'(busy), 64'd1); step();
    reset = 1'b0;
    mid();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_depth", 64'(depth), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    step();
    repeat (20) step();
    mid();
    check("final_push_q", 64'(push_q.size()), 64'd0);
    check("final_cpuq_q", 64'(cpuq_q.size()), 64'd0);
    check("final_wr_q", 64'(wr_q.size()), 64'd0);
    check("final_done_q", 64'(done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
